transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/transpose_buffer.sv | 92 +++++++++
 tb/tb_transpose_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer.sv
// Ping-pong transpose buffer between the row DCT and the column DCT.
// Rows are written into one N x N bank while the other bank is read out column by column.
module transpose_buffer #(
  parameter int W = 11,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_row,
  output logic           in_ready,
  output logic           out_valid,
  output logic [N*W-1:0] out_col,
  input  logic           out_ready,
  output logic           out_last
);

  localparam int              CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  // Each stored word is a whole row; a column is gathered by slicing every row of a bank.
  logic [N*W-1:0] mem [2][N];

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic          wr_fire;
  logic          rd_fire;
  int            rd_lsb;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    in_ready  = ~full[wr_bank];
    out_valid = full[rd_bank];
    out_last  = out_valid && (rd_cnt == LAST);
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    rd_lsb    = W * int'(rd_cnt);
  end

  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) begin
        out_col[W*k +: W] = mem[rd_bank][k][rd_lsb +: W];
      end
    end
  end

  // Write completion always targets an empty bank and read completion a full one,
  // so the two full-bit updates below never collide on the same bank.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == LAST) begin
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_cnt == LAST) begin
          rd_cnt        <= '0;
          rd_bank       <= ~rd_bank;
          full[rd_bank] <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end
    end
  end

  // NOTE: bank storage has no reset; stale contents are never visible because out_col is
  // forced to zero until a bank has been completely rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_row;
    end
  end

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer: a queue-of-blocks transpose model is compared
// against the DUT every cycle under ramp, streaming, backpressure, random, reset and gap traffic.
module tb_transpose_buffer;
  localparam int W  = 11;
  localparam int N  = 16;
  localparam int BW = N * W;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_row    = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [BW-1:0] out_col;

  transpose_buffer #(.W(W), .N(N)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_row(in_row), .in_ready(in_ready),
    .out_valid(out_valid), .out_col(out_col), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: completed blocks become N transposed columns queued in read order.
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] rows_q[$];
  logic [BW-1:0] got_q [$];

  logic          s_ir, s_ov, s_ol;
  logic [BW-1:0] s_col;

  function automatic logic exp_ov();
    return exp_q.size() != 0;
  endfunction

  function automatic logic [BW-1:0] exp_col();
    if (exp_q.size() == 0) return '0;
    return exp_q[0];
  endfunction

  function automatic logic exp_ol();
    return (exp_q.size() % N) == 1;
  endfunction

  // Input is refused only when two whole blocks are waiting to be read.
  function automatic logic exp_ir();
    int pend;
    pend = (exp_q.size() + N - 1) / N;
    return pend < 2;
  endfunction

  function automatic logic [BW-1:0] rand_row();
    logic [BW-1:0] r;
    logic [W-1:0]  v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      case ($urandom_range(7))
        0:       v = 11'h400;
        1:       v = 11'h3FF;
        default: v = W'($urandom);
      endcase
      r[W*j +: W] = v;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] ramp_row(int rr);
    logic [BW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[W*j +: W] = W'(N * rr + j);
    return r;
  endfunction

  function automatic logic [BW-1:0] ramp_col(int c);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[W*k +: W] = W'(N * k + c);
    return r;
  endfunction

  task automatic sample();
    @(negedge clk);
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_ol  = out_last;
    s_col = out_col;
  endtask

  task automatic advance();
    logic          fw, fr;
    logic [BW-1:0] row, col, r;
    fw  = in_valid && exp_ir();
    fr  = exp_ov() && out_ready;
    row = in_row;
    @(posedge clk);
    #1;
    if (fr) begin
      got_q.push_back(s_col);
      void'(exp_q.pop_front());
    end
    if (fw) rows_q.push_back(row);
    if (rows_q.size() == N) begin
      for (int c = 0; c < N; c++) begin
        col = '0;
        for (int k = 0; k < N; k++) begin
          r = rows_q[k];
          col[W*k +: W] = r[W*c +: W];
        end
        exp_q.push_back(col);
      end
      rows_q.delete();
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rstn      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    rows_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    in_valid  = 1'b1;
    in_row    = rand_row();
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    total++; if (out_col !== '0) begin bad++; $display("FAIL rst_out_col: got %h want 0", out_col); end
    do_reset();
  endtask

  task automatic test_ramp();
    int pushed = 0;
    int ncol   = 0;
    bit seen   = 0;
    for (int cyc = 0; cyc < 100 && ncol < N; cyc++) begin
      in_valid  = (pushed < N);
      in_row    = (pushed < N) ? ramp_row(pushed) : '0;
      out_ready = 1'b1;
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL ramp_cycle: got v%b l%b r%b %h want v%b l%b r%b %h",
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      if (pushed == N && !seen) begin
        seen = 1;
        total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL ramp_latency: got out_valid=%b want 1", s_ov); end
      end
      if (s_ov) begin
        total++;
        if (s_col !== ramp_col(ncol) || s_ol !== logic'(ncol == N - 1)) begin
          bad++;
          $display("FAIL ramp_col%0d: got %h last=%b want %h last=%b", ncol, s_col, s_ol,
                   ramp_col(ncol), logic'(ncol == N - 1));
        end
        ncol++;
      end
      if (in_valid && s_ir) pushed++;
      advance();
    end
    total++; if (ncol != N) begin bad++; $display("FAIL ramp_timeout: got %0d columns want %0d", ncol, N); end
    in_valid = 1'b0;
    sample();
    total++;
    if (s_ov !== 1'b0 || s_col !== '0) begin
      bad++; $display("FAIL ramp_after: got v%b %h want v0 0", s_ov, s_col);
    end
    advance();
  endtask

  task automatic test_streaming();
    logic [BW-1:0] rows[8*N];
    int pushed  = 0;
    int ncol    = 0;
    bit started = 0;
    for (int i = 0; i < 8 * N; i++) rows[i] = rand_row();
    for (int cyc = 0; cyc < 400 && ncol < 8 * N; cyc++) begin
      in_valid  = (pushed < 8 * N);
      in_row    = (pushed < 8 * N) ? rows[pushed] : '0;
      out_ready = 1'b1;
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL stream_cycle: got v%b l%b r%b %h want v%b l%b r%b %h",
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      if (pushed < 8 * N) begin
        total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL stream_ready: got %b want 1 at row %0d", s_ir, pushed); end
      end
      if (started) begin
        total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL stream_gap: got out_valid=%b want 1 at col %0d", s_ov, ncol); end
      end
      if (s_ov) begin
        started = 1;
        ncol++;
      end
      if (in_valid && s_ir) pushed++;
      advance();
    end
    total++; if (ncol != 8 * N) begin bad++; $display("FAIL stream_count: got %0d want %0d", ncol, 8 * N); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] rows[40];
    int pushed = 0;
    for (int i = 0; i < 40; i++) rows[i] = rand_row();
    for (int cyc = 0; cyc < 300 && !(pushed == 40 && exp_q.size() == 0); cyc++) begin
      in_valid  = (pushed < 40);
      in_row    = (pushed < 40) ? rows[pushed] : '0;
      out_ready = (cyc >= 40);
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL bp_cycle: got v%b l%b r%b %h want v%b l%b r%b %h",
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      if (cyc == 39) begin
        total++;
        if (pushed != 32 || s_ir !== 1'b0) begin
          bad++; $display("FAIL bp_stall: got accepted=%0d in_ready=%b want 32 and 0", pushed, s_ir);
        end
      end
      if (in_valid && s_ir) pushed++;
      advance();
    end
    total++;
    if (pushed != 40 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_timeout: got accepted=%0d pending=%0d want 40 and 0", pushed, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit            hold = 0;
    logic [BW-1:0] prev = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 800) begin
        in_valid  = 1'($urandom_range(1));
        in_row    = rand_row();
        out_ready = 1'($urandom_range(1));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL rand_cycle%0d: got v%b l%b r%b %h want v%b l%b r%b %h", cyc,
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      if (hold) begin
        total++; if (s_col !== prev) begin bad++; $display("FAIL rand_hold: got %h want %h", s_col, prev); end
      end
      hold = s_ov && !out_ready;
      prev = s_col;
      advance();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int ncol = 0;
    for (int i = 0; i < N + 7; i++) begin
      in_valid  = 1'b1;
      in_row    = rand_row();
      out_ready = (i >= N && i < N + 5);
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL rmid_fill: got v%b l%b r%b %h want v%b l%b r%b %h",
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      advance();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_col !== exp_col()) begin
      bad++; $display("FAIL rmid_col5: got v%b %h want v1 %h", out_valid, out_col, exp_col());
    end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    total++; if (out_col !== '0) begin bad++; $display("FAIL rmid_out_col: got %h want 0", out_col); end
    exp_q.delete();
    rows_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int cyc = 0; cyc < 100 && ncol < N; cyc++) begin
      in_valid  = (cyc < N);
      in_row    = rand_row();
      out_ready = 1'b1;
      sample();
      total++;
      if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
        bad++;
        $display("FAIL rmid_block: got v%b l%b r%b %h want v%b l%b r%b %h",
                 s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
      end
      if (s_ov) ncol++;
      advance();
    end
    total++; if (ncol != N) begin bad++; $display("FAIL rmid_count: got %0d want %0d", ncol, N); end
  endtask

  task automatic test_gaps();
    logic [BW-1:0] rows[N];
    logic [BW-1:0] ref_cols[$];
    int pushed;
    for (int i = 0; i < N; i++) rows[i] = rand_row();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      pushed = 0;
      for (int cyc = 0; cyc < 200 && got_q.size() < N; cyc++) begin
        in_valid  = (pushed < N) && (pass == 0 || cyc % 2 == 0);
        in_row    = in_valid ? rows[pushed] : rand_row();
        out_ready = 1'b1;
        sample();
        total++;
        if (s_ov !== exp_ov() || s_ol !== exp_ol() || s_ir !== exp_ir() || s_col !== exp_col()) begin
          bad++;
          $display("FAIL gap_cycle%0d: got v%b l%b r%b %h want v%b l%b r%b %h", pass,
                   s_ov, s_ol, s_ir, s_col, exp_ov(), exp_ol(), exp_ir(), exp_col());
        end
        if (in_valid && s_ir) pushed++;
        advance();
      end
      if (pass == 0) ref_cols = got_q;
    end
    total++; if (got_q.size() != N) begin bad++; $display("FAIL gap_count: got %0d want %0d", got_q.size(), N); end
    for (int c = 0; c < N && c < got_q.size() && c < ref_cols.size(); c++) begin
      total++;
      if (got_q[c] !== ref_cols[c]) begin
        bad++; $display("FAIL gap_col%0d: got %h want %h", c, got_q[c], ref_cols[c]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp();
    do_reset();
    test_streaming();
    do_reset();
    test_backpressure();
    do_reset();
    test_random();
    do_reset();
    test_reset_mid();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
